// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: opcodes, FSM states, default width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_div_iter.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Combinational, zero latency; no flow control.
module mdu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvsr,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_part;
    logic [WIDTH:0] w_diff;

    // The partial remainder is always below twice the divisor, so the sign bit of the
    // trial difference alone decides the quotient bit.
    assign w_part = {i_rem, i_bit};
    assign w_diff = w_part - {1'b0, i_dvsr};
    assign o_qbit = ~w_diff[WIDTH];
    assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: WIDTH+1 cycles start-to-result, busy stalls the CPU,
// starts while busy are dropped. FAST_MUL_EN selects a single-cycle combinational multiplier.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_b;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_sa     = ((op == OP_MULT) || (op == OP_DIV)) && a[WIDTH-1];
    assign w_sb     = ((op == OP_MULT) || (op == OP_DIV)) && b[WIDTH-1];
    assign w_abs_a  = w_sa ? -a : a;
    assign w_abs_b  = w_sb ? -b : b;

`ifdef FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`endif

    // Shift-add: multiplier |a| shifts out of r_q, multiplicand |b| sits in r_b.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_q[0] ? r_b : {WIDTH{1'b0}})};

    mdu_div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .i_rem  (r_acc[2*WIDTH-1:WIDTH]),
        .i_bit  (r_q[WIDTH-1]),
        .i_dvsr (r_b),
        .o_rem  (w_div_rem),
        .o_qbit (w_qbit)
    );

    // Divide by zero keeps the all-ones quotient unsigned so LO reads back as -1 pattern.
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = (r_neg_q && !r_dz) ? -r_q : r_q;
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && w_is_mul) begin
`ifdef FAST_MUL_EN
                    w_state_nxt = S_FIN;
`else
                    w_state_nxt = S_MUL;
`endif
                end else if (start && w_is_div) begin
                    w_state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == LAST_STEP) w_state_nxt = S_FIN;
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_q      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_dz     <= (b == '0);
`ifdef FAST_MUL_EN
                        r_acc    <= w_is_mul ? w_fast_prod : '0;
`else
                        r_acc    <= '0;
`endif
                        if (op == OP_MTHI) r_hi <= a;
                        if (op == OP_MTLO) r_lo <= a;
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_q   <= r_q >> 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_acc[2*WIDTH-1:WIDTH] <= w_div_rem;
                    r_q   <= {r_q[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIN: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized scoreboard bench for mul_div_unit against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
    import mdu_pkg::*;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics via 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] f_op, input logic [31:0] fa,
                                          input logic [31:0] fb);
        longint sa;
        longint sb;
        longint r64;
        longint q64;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        case (f_op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return {32'b0, fa} * {32'b0, fb};
            OP_DIV: begin
                if (fb == 0) return {fa, 32'hFFFF_FFFF};
                q64 = sa / sb;
                r64 = sa % sb;
                return {r64[31:0], q64[31:0]};
            end
            default: begin
                if (fb == 0) return {fa, 32'hFFFF_FFFF};
                return {fb == 0 ? 32'h0 : fa % fb, fa / fb};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rstn && done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("hi", {32'b0, hi}, {32'b0, e[63:32]});
                    chk("lo", {32'b0, lo}, {32'b0, e[31:0]});
                end
            end
        end
    end

    // Issue one mul/div op at a negedge; returns at the negedge of its done cycle.
    task automatic issue(input logic [2:0] t_op, input logic [31:0] ta, input logic [31:0] tb,
                         input bit inject);
        int cnt;
        int guard;
        int lat;
        logic [63:0] e;
        e = model(t_op, ta, tb);
        exp_q.push_back(e);
        lat = (t_op == OP_MULT || t_op == OP_MULTU) ? MUL_LAT : DIV_LAT;
        start = 1'b1; op = t_op; a = ta; b = tb;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        guard = 0;
        while (!done && guard < 100) begin
            if (busy) cnt++;
            if (cnt == 2 && lat > 2) chk("hold_hi", {32'b0, hi}, {32'b0, m_hi});
            if (inject && cnt == 3) begin
                start = 1'b1; op = OP_MTLO; a = 32'hA5A5_A5A5;
            end else if (start) begin
                start = 1'b0;
                chk("mtlo_busy_ignored", {32'b0, lo}, {32'b0, m_lo});
            end
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        if (guard >= 100) chk("done_timeout", 64'd1, 64'd0);
        chk("busy_cycles", 64'(cnt), 64'(lat));
        chk("busy_low_in_done", {63'b0, busy}, 64'd0);
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    task automatic mt(input logic [2:0] t_op, input logic [31:0] ta);
        start = 1'b1; op = t_op; a = ta; b = 32'h0;
        @(negedge clk);
        start = 1'b0;
        if (t_op == OP_MTHI) m_hi = ta;
        else                 m_lo = ta;
        chk("mt_hi", {32'b0, hi}, {32'b0, m_hi});
        chk("mt_lo", {32'b0, lo}, {32'b0, m_lo});
        chk("mt_no_done", {62'b0, done, busy}, 64'd0);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] ra;
        logic [31:0] rb;
        rstn = 1'b1; start = 1'b0; op = 3'b0; a = '0; b = '0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        mt(OP_MTHI, 32'hA5A5_A5A5);
        mt(OP_MTLO, 32'h1234_5678);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(OP_MULT,  32'hFFFF_FFFD, 32'd7, 1'b0);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(OP_DIVU,  32'd100, 32'd7, 1'b0);
        issue(OP_DIVU,  32'h0000_1234, 32'd0, 1'b0);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            r_op = 3'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1, 2:    rb = 32'($urandom_range(1, 300)) ^ {32{ra[0]}};
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) mt(OP_MTHI, $urandom);
            issue(r_op, ra, rb, 1'b0);
        end

        // Abort a divide mid-flight; nothing may complete from it.
        start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_hi", {32'b0, hi}, 64'd0);
        chk("abort_lo", {32'b0, lo}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        issue(OP_MULTU, 32'd5, 32'd6, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
